read_burst_fsm: RTL and testbench
=================================

# read_burst_fsm

Parametrised burst read sequencer for the near-memory-compute macro. It sits between the top-level controller and the sense-amplifier (SA) / address decoder path. Each start command issues a burst of `burst_len` SA reads at a programmable stride. Every word goes back to the top through a valid/ready handshake, and a watchdog aborts the burst if the SA never answers.

## Interface

Parameters:
- `DATA_W`, default 9: SA word width.
- `ADDR_W`, default 21: decoder address width.
- `LEN_W`, default 8: width of the burst length.
- `ROW_STRIDE`, default 128: address increment in mode 1.
- `SA_TIMEOUT`, default 64: maximum cycles spent in SENSE per word, ≥2.

Ports:
- `sys_clk`  in  1  single clock, all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sys_en`  in  1  block enable. Low forces IDLE.
- `start`  in  1  burst request. Sampled only in IDLE.
- `mode`  in  1  0 = column mode, stride 1, full word. 1 = row mode, stride `ROW_STRIDE`, LSB of the word forced to 0.
- `init_addr`  in  `ADDR_W`  first address of the burst.
- `burst_len`  in  `LEN_W`  number of words to read.
- `sa_done`  in  1  SA result valid.
- `sa_data`  in  `DATA_W`  SA result.
- `sa_en`  out  1  SA sense enable.
- `address`  out  `ADDR_W`  decoder address.
- `out_valid`  out  1  `data_out` / `out_addr` valid.
- `out_ready`  in  1  top accepts the word.
- `data_out`  out  `DATA_W`  captured word.
- `out_addr`  out  `ADDR_W`  address the word was read from.
- `busy`  out  1  a burst is in progress.
- `done`  out  1  one-cycle pulse at burst end.
- `timeout_err`  out  1  sticky flag: the watchdog fired.

## Operation

- All outputs are registered. Reset value of every output is 0.
- States:
  - IDLE:
    - `start & sys_en` latches `init_addr`, `burst_len` and `mode`. Later changes to these inputs during the burst are ignored.
    - The same event clears `timeout_err`.
    - If `burst_len` = 0, go to DONE; otherwise go to SENSE.
  - SENSE:
    - `sa_en` = 1 and `address` is stable. The watchdog counter increments each cycle.
    - On `sa_done` = 1, capture the word and go to PUSH:
      - `data_out` = `sa_data` in mode 0.
      - `data_out` = {`sa_data[DATA_W-1:1]`, 1'b0} in mode 1.
      - `out_addr` = `address`.
    - If the counter reaches `SA_TIMEOUT`-1 without `sa_done`, set `timeout_err` and go to DONE. No word is pushed.
  - PUSH:
    - `out_valid` = 1 and `sa_en` = 0. `data_out` and `out_addr` are held until `out_valid & out_ready`.
    - On that handshake:
      - `address` += 1 (mode 0) or `ROW_STRIDE` (mode 1), modulo 2^`ADDR_W` (wraps silently).
      - The remaining count decrements.
      - If the remaining count is 0, go to DONE; otherwise reset the watchdog and go to SENSE.
  - DONE: `done` = 1 for exactly one cycle, `busy` = 0 next cycle, return to IDLE.
- `busy` = 1 in SENSE, PUSH and DONE.
- `sys_en` low in any state:
  - Next state is IDLE.
  - `sa_en`, `out_valid` and `busy` are cleared. `done` is not pulsed.
  - `timeout_err` is held.
- `start` while busy is ignored. `sa_done` outside SENSE is ignored.
- Asynchronous reset mid-burst returns to IDLE with all outputs 0 on the next observable edge.

## Timing

- From `start` sampled in IDLE, `sa_en` rises on the next cycle.
- `sa_done` sampled high in SENSE makes `out_valid` high on the next cycle, with `sa_en` low in that same cycle.
- Best case is 2 cycles per word (`sa_done` in the first SENSE cycle and `out_ready` held high). A burst of N words then takes 2N+1 cycles from the first `sa_en` to the `done` pulse.
- Zero-length burst: `done` pulses 1 cycle after `start`.
- `address` changes only on the PUSH handshake edge or on the IDLE latch. It is never changed while `sa_en` = 1.

## Structure

- Shared package `nmc_read_pkg` holds:
  - the state enum (IDLE, SENSE, PUSH, DONE),
  - the mode constants `MODE_COL`=0 and `MODE_ROW`=1,
  - the default `ROW_STRIDE`.
- One sub-module, `sa_watchdog`: a parametrised `SA_TIMEOUT` cycle counter with clear/enable inputs and an `expired` output. It is reusable by the write sequencer.

## Test plan

- Mode 0, `init_addr`=0x00010, `burst_len`=4, `sa_done` high at the first SENSE cycle, `out_ready`=1 → four words at `out_addr` 0x10–0x13, each `data_out`=`sa_data`. `done` pulses 9 cycles after the first `sa_en`.
- Mode 1, `init_addr`=0x1FFF80, `burst_len`=3, `sa_data`=9'h1FF → `data_out`=9'h1FE each time. Addresses are 0x1FFF80, 0x000000 (wrap), 0x000080.
- `out_ready` held low 5 cycles in PUSH → `out_valid`, `data_out` and `out_addr` stable for all 6 cycles, `sa_en` stays 0, `address` unchanged until the handshake.
- `sa_done` never asserted, `SA_TIMEOUT`=64 → after 64 SENSE cycles `timeout_err`=1, `done` pulses, no `out_valid`. The next `start` clears `timeout_err`.
- `sys_en` dropped during the second SENSE of a 4-word burst → IDLE next cycle, `sa_en`=`busy`=0, no `done` pulse. `burst_len`=0 → `done` 1 cycle after `start` with no `sa_en`.

Source files
------------

// File: rtl/nmc_read_pkg.sv
// Shared definitions for the near-memory-compute read path.
//   - FSM state encodings for the burst read sequencer
//   - burst mode constants (column / row)
//   - default row stride
package nmc_read_pkg;

  // Sequencer states
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSense = 2'd1;
  localparam logic [1:0] StPush  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Burst modes
  localparam logic MODE_COL = 1'b0;  // stride 1, full word
  localparam logic MODE_ROW = 1'b1;  // stride ROW_STRIDE, word LSB forced to 0

  localparam int unsigned DEFAULT_ROW_STRIDE = 128;

endpackage

// File: rtl/sa_watchdog.sv
// Sense-amplifier watchdog counter.
// Counts enabled cycles from 0 and flags 'expired' once the count reaches TIMEOUT-1;
// the count then holds until cleared.
// Ports:
//   sys_clk  - clock
//   rst_n    - asynchronous active-low reset
//   clear    - synchronous clear to 0 (wins over enable)
//   enable   - count this cycle
//   expired  - count == TIMEOUT-1
module sa_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] count_q, count_d;

  assign expired = (count_q == CntW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/read_burst_fsm.sv
// Burst read sequencer: on start, issues burst_len sense-amplifier reads at stride 1 (column
// mode) or ROW_STRIDE (row mode), returning each word over a valid/ready handshake. A
// watchdog aborts the burst if the SA does not answer within SA_TIMEOUT cycles.
// Ports:
//   sys_clk, rst_n          - clock, asynchronous active-low reset
//   sys_en                  - block enable; low forces IDLE
//   start, mode, init_addr, burst_len - burst request (sampled in IDLE only)
//   sa_done, sa_data        - SA result
//   sa_en, address          - SA sense enable and decoder address
//   out_valid, out_ready, data_out, out_addr - word return handshake
//   busy, done, timeout_err - status (done is a one-cycle pulse, timeout_err is sticky)
module read_burst_fsm
  import nmc_read_pkg::*;
#(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned ROW_STRIDE = DEFAULT_ROW_STRIDE,
  parameter int unsigned SA_TIMEOUT = 64
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sys_en,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              sa_done,
  input  logic [DATA_W-1:0] sa_data,
  output logic              sa_en,
  output logic [ADDR_W-1:0] address,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              terr_q, terr_d;
  logic              sa_en_q, valid_q, busy_q, done_q;
  logic              wd_expired;

  // Watchdog counts SENSE cycles only; leaving SENSE re-arms it for the next word.
  sa_watchdog #(
    .TIMEOUT (SA_TIMEOUT)
  ) u_sa_watchdog (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clear   (state_q != StSense),
    .enable  (state_q == StSense),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    mode_d  = mode_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    terr_d  = terr_q;

    if (!sys_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_d  = init_addr;
            len_d   = burst_len;
            mode_d  = mode;
            terr_d  = 1'b0;
            state_d = (burst_len == '0) ? StDone : StSense;
          end
        end
        StSense: begin
          // A word arriving on the last watchdog cycle still counts.
          if (sa_done) begin
            data_d = sa_data;
            if (mode_q == MODE_ROW) begin
              data_d[0] = 1'b0;
            end
            oaddr_d = addr_q;
            state_d = StPush;
          end else if (wd_expired) begin
            terr_d  = 1'b1;
            state_d = StDone;
          end
        end
        StPush: begin
          if (out_ready) begin
            addr_d  = addr_q + ((mode_q == MODE_ROW) ? ADDR_W'(ROW_STRIDE) : ADDR_W'(1));
            len_d   = len_q - LEN_W'(1);
            state_d = (len_q <= LEN_W'(1)) ? StDone : StSense;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      mode_q  <= MODE_COL;
      data_q  <= '0;
      oaddr_q <= '0;
      terr_q  <= 1'b0;
      sa_en_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      terr_q  <= terr_d;
      // Status outputs are registered copies of the next-state decode.
      sa_en_q <= (state_d == StSense);
      valid_q <= (state_d == StPush);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
    end
  end

  assign sa_en       = sa_en_q;
  assign address     = addr_q;
  assign out_valid   = valid_q;
  assign data_out    = data_q;
  assign out_addr    = oaddr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_read_burst_fsm.sv
// Directed self-checking bench for read_burst_fsm (default parameters).
module tb_read_burst_fsm;

  logic        sys_clk;
  logic        rst_n;
  logic        sys_en;
  logic        start;
  logic        mode;
  logic [20:0] init_addr;
  logic [7:0]  burst_len;
  logic        sa_done;
  logic [8:0]  sa_data;
  logic        sa_en;
  logic [20:0] address;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  data_out;
  logic [20:0] out_addr;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  read_burst_fsm dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .sys_en      (sys_en),
    .start       (start),
    .mode        (mode),
    .init_addr   (init_addr),
    .burst_len   (burst_len),
    .sa_done     (sa_done),
    .sa_data     (sa_data),
    .sa_en       (sa_en),
    .address     (address),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL tb_time_limit: got no finish, want finish before 500us");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".sa_en"},       32'(sa_en),       32'd0);
    check_eq({tag, ".out_valid"},   32'(out_valid),   32'd0);
    check_eq({tag, ".busy"},        32'(busy),        32'd0);
    check_eq({tag, ".done"},        32'(done),        32'd0);
    check_eq({tag, ".address"},     32'(address),     32'd0);
    check_eq({tag, ".data_out"},    32'(data_out),    32'd0);
    check_eq({tag, ".out_addr"},    32'(out_addr),    32'd0);
    check_eq({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // Best-case burst: sa_done and out_ready held high, so each word takes 2 cycles.
  // Word i reads sa_data = din + i*dstep; row mode expects the LSB cleared.
  task automatic run_burst(input logic m, input logic [20:0] a0, input logic [7:0] len,
                           input logic [8:0] din, input logic [8:0] dstep,
                           input int stride, input string tag);
    logic [20:0] ea;
    logic [8:0]  dv;
    logic [8:0]  ev;
    sys_en    = 1'b1;
    sa_done   = 1'b1;
    out_ready = 1'b1;
    mode      = m;
    init_addr = a0;
    burst_len = len;
    start     = 1'b1;
    step();
    start     = 1'b0;
    init_addr = ~a0;  // must be ignored after the latch
    burst_len = 8'd1;
    mode      = ~m;
    for (int i = 0; i < int'(len); i++) begin
      ea = a0 + 21'(i * stride);
      dv = din + 9'(i * int'(dstep));
      ev = m ? {dv[8:1], 1'b0} : dv;
      sa_data = dv;
      check_eq($sformatf("%s.w%0d.sa_en", tag, i), 32'(sa_en), 32'd1);
      check_eq($sformatf("%s.w%0d.address", tag, i), 32'(address), 32'(ea));
      step();
      check_eq($sformatf("%s.w%0d.out_valid", tag, i), 32'(out_valid), 32'd1);
      check_eq($sformatf("%s.w%0d.sa_en_push", tag, i), 32'(sa_en), 32'd0);
      check_eq($sformatf("%s.w%0d.data_out", tag, i), 32'(data_out), 32'(ev));
      check_eq($sformatf("%s.w%0d.out_addr", tag, i), 32'(out_addr), 32'(ea));
      step();
    end
    // 2N edges after the first sa_en cycle: done is the (2N+1)th cycle of the burst.
    check_eq({tag, ".done"}, 32'(done), 32'd1);
    check_eq({tag, ".busy_done"}, 32'(busy), 32'd1);
    check_eq({tag, ".valid_done"}, 32'(out_valid), 32'd0);
    step();
    check_eq({tag, ".done_end"}, 32'(done), 32'd0);
    check_eq({tag, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic seen_valid;
    rst_n     = 1'b0;
    sys_en    = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    init_addr = '0;
    burst_len = '0;
    sa_done   = 1'b0;
    sa_data   = '0;
    out_ready = 1'b0;
    #23;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check_all_zero("idle");

    // Column mode, 4 words from 0x10.
    run_burst(1'b0, 21'h00010, 8'd4, 9'h0A5, 9'h011, 1, "col4");

    // Row mode, 3 words across the address wrap, LSB of 0x1FF forced low.
    run_burst(1'b1, 21'h1FFF80, 8'd3, 9'h1FF, 9'h000, 128, "row3");

    // Backpressure: out_ready low for 5 cycles in PUSH.
    sys_en    = 1'b1;
    mode      = 1'b0;
    init_addr = 21'h00100;
    burst_len = 8'd2;
    sa_done   = 1'b1;
    sa_data   = 9'h055;
    out_ready = 1'b0;
    start     = 1'b1;
    step();
    step();
    sa_data   = 9'h0AA;   // must not disturb the held word
    init_addr = 21'h1FFFF;
    burst_len = 8'd0;     // start is still high: a new request must be ignored while busy
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("bp.c%0d.out_valid", k), 32'(out_valid), 32'd1);
      check_eq($sformatf("bp.c%0d.data_out", k), 32'(data_out), 32'h055);
      check_eq($sformatf("bp.c%0d.out_addr", k), 32'(out_addr), 32'h100);
      check_eq($sformatf("bp.c%0d.sa_en", k), 32'(sa_en), 32'd0);
      check_eq($sformatf("bp.c%0d.address", k), 32'(address), 32'h100);
      if (k == 5) begin
        out_ready = 1'b1;
        start     = 1'b0;
      end
      step();
    end
    check_eq("bp.sense2.sa_en", 32'(sa_en), 32'd1);
    check_eq("bp.sense2.address", 32'(address), 32'h101);
    step();
    check_eq("bp.push2.data_out", 32'(data_out), 32'h0AA);
    check_eq("bp.push2.out_addr", 32'(out_addr), 32'h101);
    step();
    check_eq("bp.done", 32'(done), 32'd1);
    step();

    // Watchdog: sa_done never arrives.
    sa_done    = 1'b0;
    out_ready  = 1'b1;
    init_addr  = 21'h00020;
    burst_len  = 8'd2;
    start      = 1'b1;
    step();
    start      = 1'b0;
    seen_valid = 1'b0;
    for (int c = 1; c < 64; c++) begin
      if (out_valid) seen_valid = 1'b1;
      step();
    end
    check_eq("wd.sense64.sa_en", 32'(sa_en), 32'd1);
    check_eq("wd.sense64.timeout_err", 32'(timeout_err), 32'd0);
    step();
    check_eq("wd.done", 32'(done), 32'd1);
    check_eq("wd.timeout_err", 32'(timeout_err), 32'd1);
    check_eq("wd.sa_en_off", 32'(sa_en), 32'd0);
    check_eq("wd.no_valid", 32'(seen_valid | out_valid), 32'd0);
    step();
    check_eq("wd.idle.busy", 32'(busy), 32'd0);
    check_eq("wd.idle.timeout_err_held", 32'(timeout_err), 32'd1);

    // Zero-length burst: done one cycle after start, clears timeout_err, no sa_en.
    burst_len = 8'd0;
    start     = 1'b1;
    step();
    start     = 1'b0;
    check_eq("zero.done", 32'(done), 32'd1);
    check_eq("zero.sa_en", 32'(sa_en), 32'd0);
    check_eq("zero.timeout_err_cleared", 32'(timeout_err), 32'd0);
    step();
    check_eq("zero.done_end", 32'(done), 32'd0);

    // sys_en dropped in the second SENSE of a 4-word burst.
    sa_done   = 1'b1;
    out_ready = 1'b1;
    sa_data   = 9'h033;
    init_addr = 21'h00040;
    burst_len = 8'd4;
    start     = 1'b1;
    step();
    start     = 1'b0;
    step();
    step();
    check_eq("en.sense2.sa_en", 32'(sa_en), 32'd1);
    check_eq("en.sense2.address", 32'(address), 32'h041);
    sys_en = 1'b0;
    step();
    check_eq("en.off.sa_en", 32'(sa_en), 32'd0);
    check_eq("en.off.busy", 32'(busy), 32'd0);
    check_eq("en.off.out_valid", 32'(out_valid), 32'd0);
    check_eq("en.off.done", 32'(done), 32'd0);
    step();
    check_eq("en.off2.done", 32'(done), 32'd0);
    sys_en = 1'b1;
    step();
    check_eq("en.back.busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a burst.
    out_ready = 1'b0;
    start     = 1'b1;
    step();
    start     = 1'b0;
    step();
    check_eq("ar.push.out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("ar");
    #1;
    rst_n = 1'b1;
    step();
    check_eq("ar.after.busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
